dw_multi_alarm_watch: RTL and testbench

DW_MULTI_ALARM_WATCH -- requirements
Module: dw_multi_alarm_watch

---
 rtl/dw_pkg.sv | 15 +
 rtl/dw_sec_tick.sv | 26 ++
 rtl/dw_multi_alarm_watch.sv | 238 +++++++++++++++++++++++
 tb/tb_dw_multi_alarm_watch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dw_pkg.sv
// Shared types and calendar constants for the multi-alarm watch.
package dw_pkg;
    typedef enum logic [2:0] {
        S_TIME    = 3'd0,
        S_SET_HR  = 3'd1,
        S_SET_MIN = 3'd2,
        S_ALM_HR  = 3'd3,
        S_ALM_MIN = 3'd4,
        S_SW      = 3'd5
    } state_e;

    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HR    = 60;
    localparam int SEC_PER_MIN   = 60;
endpackage

// File: rtl/dw_sec_tick.sv
// One-second prescaler: a single-cycle tick at the terminal count, held at zero while hold is high.
module dw_sec_tick #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);
    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (hold || cnt_q == TERM) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign tick = !hold && (cnt_q == TERM);
endmodule

// File: rtl/dw_multi_alarm_watch.sv
// Digital watch: time of day, N alarms with auto-stop ringing, stopwatch, 12/24h BCD display.
module dw_multi_alarm_watch
    import dw_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int N_ALARMS      = 2,
    parameter int RING_SEC      = 30,
    localparam int IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                set,
    input  logic                alarm_ack,
    input  logic                sw_clr,
    input  logic                fmt_12h,
    output logic [1:0]          tens_hours_out,
    output logic [3:0]          units_hours_out,
    output logic [2:0]          tens_minutes_out,
    output logic [3:0]          units_minutes_out,
    output logic [5:0]          seconds_out,
    output logic                pm_out,
    output logic                alarm_sound,
    output logic [IW-1:0]       alarm_idx_out,
    output logic [N_ALARMS-1:0] alarm_en_out,
    output logic [2:0]          state_out,
    output logic [5:0]          stopwatch_min_out,
    output logic [5:0]          stopwatch_sec_out
);
    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4:0]            hour_q, hour_d;
    logic [5:0]            min_q, min_d, sec_q, sec_d;
    logic [4:0]            alm_hr_q [N_ALARMS];
    logic [4:0]            alm_hr_d [N_ALARMS];
    logic [5:0]            alm_min_q [N_ALARMS];
    logic [5:0]            alm_min_d [N_ALARMS];
    logic [N_ALARMS-1:0]   alm_en_q, alm_en_d;
    logic                  ring_q, ring_d;
    logic [IW-1:0]         ring_idx_q, ring_idx_d;
    logic [5:0]            ring_cnt_q, ring_cnt_d;
    logic                  sw_run_q, sw_run_d;
    logic [5:0]            sw_min_q, sw_min_d, sw_sec_q, sw_sec_d;

    logic                  tick, hold, alm_state, time_adv, trig;
    logic [N_ALARMS-1:0]   match;
    logic [IW-1:0]         trig_idx;

    assign hold      = (state_q == S_SET_HR) || (state_q == S_SET_MIN);
    assign alm_state = (state_q == S_ALM_HR) || (state_q == S_ALM_MIN);

    dw_sec_tick #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .hold (hold),
        .tick (tick)
    );

    // UI state machine and alarm-field editing.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        alm_hr_d  = alm_hr_q;
        alm_min_d = alm_min_q;
        alm_en_d  = alm_en_q;
        if (mode) begin
            case (state_q)
                S_TIME:    state_d = S_SET_HR;
                S_SET_HR:  state_d = S_SET_MIN;
                S_SET_MIN: begin state_d = S_ALM_HR; idx_d = '0; end
                S_ALM_HR:  state_d = S_ALM_MIN;
                S_ALM_MIN: begin
                    if (int'(idx_q) < N_ALARMS - 1) begin
                        state_d = S_ALM_HR;
                        idx_d   = idx_q + 1'b1;
                    end else begin
                        state_d = S_SW;
                        idx_d   = '0;
                    end
                end
                default:   state_d = S_TIME;
            endcase
        end else if (alm_state) begin
            if (set) begin
                if (state_q == S_ALM_HR)
                    alm_hr_d[idx_q] = (alm_hr_q[idx_q] == 5'(HOURS_PER_DAY - 1)) ? '0 : alm_hr_q[idx_q] + 1'b1;
                else
                    alm_min_d[idx_q] = (alm_min_q[idx_q] == 6'(MIN_PER_HR - 1)) ? '0 : alm_min_q[idx_q] + 1'b1;
                alm_en_d[idx_q] = 1'b1;
            end else if (alarm_ack && !ring_q) begin
                alm_en_d[idx_q] = !alm_en_q[idx_q];
            end
        end
    end

    // Time of day: frozen while setting, seconds zeroed when entering hour-set.
    always_comb begin
        hour_d   = hour_q;
        min_d    = min_q;
        sec_d    = sec_q;
        time_adv = 1'b0;
        if (mode && state_q == S_TIME) begin
            sec_d = '0;
        end else if (state_q == S_SET_HR) begin
            if (set && !mode) hour_d = (hour_q == 5'(HOURS_PER_DAY - 1)) ? '0 : hour_q + 1'b1;
        end else if (state_q == S_SET_MIN) begin
            if (set && !mode) min_d = (min_q == 6'(MIN_PER_HR - 1)) ? '0 : min_q + 1'b1;
        end else if (tick) begin
            time_adv = 1'b1;
            if (sec_q == 6'(SEC_PER_MIN - 1)) begin
                sec_d = '0;
                if (min_q == 6'(MIN_PER_HR - 1)) begin
                    min_d  = '0;
                    hour_d = (hour_q == 5'(HOURS_PER_DAY - 1)) ? '0 : hour_q + 1'b1;
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_match
            assign match[gi] = alm_en_q[gi] && (alm_hr_q[gi] == hour_d) && (alm_min_q[gi] == min_d);
        end
    endgenerate

    always_comb begin
        trig_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--)
            if (match[i]) trig_idx = IW'(i);
    end

    assign trig = time_adv && !alm_state && (sec_d == '0) && (|match);

    // A fresh trigger beats a same-cycle acknowledge and restarts the ring timer.
    always_comb begin
        ring_d     = ring_q;
        ring_idx_d = ring_idx_q;
        ring_cnt_d = ring_cnt_q;
        if (trig) begin
            ring_d     = 1'b1;
            ring_idx_d = trig_idx;
            ring_cnt_d = '0;
        end else if (ring_q) begin
            if (alarm_ack || (tick && ring_cnt_q == 6'(RING_SEC - 1))) begin
                ring_d     = 1'b0;
                ring_idx_d = '0;
                ring_cnt_d = '0;
            end else if (tick) begin
                ring_cnt_d = ring_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        sw_run_d = sw_run_q;
        sw_min_d = sw_min_q;
        sw_sec_d = sw_sec_q;
        if (set && !mode && state_q == S_SW) sw_run_d = !sw_run_q;
        if (sw_clr) begin
            sw_min_d = '0;
            sw_sec_d = '0;
        end else if (sw_run_q && tick) begin
            if (sw_sec_q == 6'(SEC_PER_MIN - 1)) begin
                sw_sec_d = '0;
                sw_min_d = (sw_min_q == 6'(MIN_PER_HR - 1)) ? '0 : sw_min_q + 1'b1;
            end else begin
                sw_sec_d = sw_sec_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_TIME;
            idx_q      <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            alm_hr_q   <= '{default: '0};
            alm_min_q  <= '{default: '0};
            alm_en_q   <= '0;
            ring_q     <= 1'b0;
            ring_idx_q <= '0;
            ring_cnt_q <= '0;
            sw_run_q   <= 1'b0;
            sw_min_q   <= '0;
            sw_sec_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            alm_hr_q   <= alm_hr_d;
            alm_min_q  <= alm_min_d;
            alm_en_q   <= alm_en_d;
            ring_q     <= ring_d;
            ring_idx_q <= ring_idx_d;
            ring_cnt_q <= ring_cnt_d;
            sw_run_q   <= sw_run_d;
            sw_min_q   <= sw_min_d;
            sw_sec_q   <= sw_sec_d;
        end
    end

    // Display path: choose source, fold to 12h if asked, split to BCD digits.
    logic [4:0] disp_hr, h12;
    logic [5:0] disp_min;
    always_comb begin
        disp_hr  = alm_state ? alm_hr_q[idx_q]  : hour_q;
        disp_min = alm_state ? alm_min_q[idx_q] : min_q;
        h12      = disp_hr;
        pm_out   = 1'b0;
        if (fmt_12h) begin
            pm_out = (disp_hr >= 5'd12);
            if (disp_hr == 5'd0)       h12 = 5'd12;
            else if (disp_hr > 5'd12)  h12 = disp_hr - 5'd12;
        end
        tens_hours_out  = (h12 >= 5'd20) ? 2'd2 : (h12 >= 5'd10) ? 2'd1 : 2'd0;
        units_hours_out = 4'(h12 - 5'(tens_hours_out) * 5'd10);
        tens_minutes_out = '0;
        for (int k = 1; k < 6; k++)
            if (disp_min >= 6'(k * 10)) tens_minutes_out = 3'(k);
        units_minutes_out = 4'(disp_min - 6'(tens_minutes_out) * 6'd10);
    end

    assign seconds_out       = sec_q;
    assign alarm_sound       = ring_q;
    assign alarm_idx_out     = alm_state ? idx_q : (ring_q ? ring_idx_q : '0);
    assign alarm_en_out      = alm_en_q;
    assign state_out         = state_q;
    assign stopwatch_min_out = sw_min_q;
    assign stopwatch_sec_out = sw_sec_q;
endmodule

// File: tb/tb_dw_multi_alarm_watch.sv
// Directed bench for dw_multi_alarm_watch with TICKS_PER_SEC=4, N_ALARMS=2, RING_SEC=3.
module tb_dw_multi_alarm_watch;
    localparam int T = 4;
    localparam int N = 2;
    localparam int R = 3;

    logic clk = 1'b0, rst = 1'b0;
    logic mode = 1'b0, set = 1'b0, alarm_ack = 1'b0, sw_clr = 1'b0, fmt_12h = 1'b0;
    logic [1:0] tens_hours_out;
    logic [3:0] units_hours_out;
    logic [2:0] tens_minutes_out;
    logic [3:0] units_minutes_out;
    logic [5:0] seconds_out;
    logic       pm_out, alarm_sound;
    logic [0:0] alarm_idx_out;
    logic [1:0] alarm_en_out;
    logic [2:0] state_out;
    logic [5:0] stopwatch_min_out, stopwatch_sec_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dw_multi_alarm_watch #(.TICKS_PER_SEC(T), .N_ALARMS(N), .RING_SEC(R)) dut (
        .clk(clk), .rst(rst), .mode(mode), .set(set), .alarm_ack(alarm_ack),
        .sw_clr(sw_clr), .fmt_12h(fmt_12h),
        .tens_hours_out(tens_hours_out), .units_hours_out(units_hours_out),
        .tens_minutes_out(tens_minutes_out), .units_minutes_out(units_minutes_out),
        .seconds_out(seconds_out), .pm_out(pm_out), .alarm_sound(alarm_sound),
        .alarm_idx_out(alarm_idx_out), .alarm_en_out(alarm_en_out),
        .state_out(state_out), .stopwatch_min_out(stopwatch_min_out),
        .stopwatch_sec_out(stopwatch_sec_out)
    );

    typedef struct {
        logic m, s, a;
        int   st, idx, en, hh, mm;
    } vec_t;
    vec_t vt [16];

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int hh();
        return int'(tens_hours_out) * 10 + int'(units_hours_out);
    endfunction
    function automatic int mm();
        return int'(tens_minutes_out) * 10 + int'(units_minutes_out);
    endfunction

    task automatic pulse_mode(input int n);
        for (int i = 0; i < n; i++) begin mode = 1'b1; step(); mode = 1'b0; end
    endtask
    task automatic pulse_set(input int n);
        for (int i = 0; i < n; i++) begin set = 1'b1; step(); set = 1'b0; end
    endtask

    task automatic do_reset();
        mode = 1'b0; set = 1'b0; alarm_ack = 1'b0; sw_clr = 1'b0; fmt_12h = 1'b0;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    // From S_TIME: hour/min incremented hp/mp times, ending back in S_TIME with
    // seconds at 1; the following seconds ticks land every 4th edge.
    task automatic goto_time(input int hp, input int mp);
        pulse_mode(1);
        pulse_set(hp);
        pulse_mode(1);
        pulse_set(mp);
        pulse_mode(6);
    endtask

    task automatic prog_alarms_0630();
        pulse_mode(3);
        pulse_set(6);
        pulse_mode(1);
        pulse_set(30);
        pulse_mode(1);
        pulse_set(6);
        pulse_mode(1);
        pulse_set(30);
        pulse_mode(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ring_len;
        int waited;

        vt[0]  = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1, 0, 0, 1, 0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 2, 0, 0, 1, 0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 2, 0, 0, 1, 1};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 3, 0, 0, 0, 0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 3, 0, 1, 1, 0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 3, 0, 0, 1, 0};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 4, 0, 0, 1, 0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 4, 0, 1, 1, 1};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 3, 1, 1, 0, 0};
        vt[10] = '{1'b0, 1'b0, 1'b1, 3, 1, 3, 0, 0};
        vt[11] = '{1'b1, 1'b0, 1'b0, 4, 1, 3, 0, 0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 5, 0, 3, 1, 1};
        vt[13] = '{1'b0, 1'b1, 1'b0, 5, 0, 3, 1, 1};
        vt[14] = '{1'b1, 1'b1, 1'b0, 0, 0, 3, 1, 1};
        vt[15] = '{1'b0, 1'b0, 1'b0, 0, 0, 3, 1, 1};

        // Reset values and first-tick latency
        step(2);
        check("rst_state", int'(state_out), 0);
        check("rst_sound", int'(alarm_sound), 0);
        check("rst_en", int'(alarm_en_out), 0);
        check("rst_hhmm_24h", hh() * 100 + mm(), 0);
        check("rst_pm", int'(pm_out), 0);
        fmt_12h = 1'b1;
        #1;
        check("rst_hh_12h", hh(), 12);
        check("rst_pm_12h", int'(pm_out), 0);
        fmt_12h = 1'b0;
        rst = 1'b1;
        step(3);
        check("first_tick_pre", int'(seconds_out), 0);
        step(1);
        check("first_tick", int'(seconds_out), 1);

        // FSM and alarm-edit table
        for (int i = 0; i < 16; i++) begin
            mode = vt[i].m; set = vt[i].s; alarm_ack = vt[i].a;
            step();
            mode = 1'b0; set = 1'b0; alarm_ack = 1'b0;
            $display("row %0d: state=%0d idx=%0d en=%0d disp=%0d:%0d", i,
                     state_out, alarm_idx_out, alarm_en_out, hh(), mm());
            check($sformatf("row%0d_state", i), int'(state_out), vt[i].st);
            check($sformatf("row%0d_idx", i), int'(alarm_idx_out), vt[i].idx);
            check($sformatf("row%0d_en", i), int'(alarm_en_out), vt[i].en);
            check($sformatf("row%0d_hh", i), hh(), vt[i].hh);
            check($sformatf("row%0d_mm", i), mm(), vt[i].mm);
        end
        check("table_no_ring", int'(alarm_sound), 0);

        // 12h display while hour is being set
        do_reset();
        pulse_mode(1);
        pulse_set(12);
        fmt_12h = 1'b1;
        #1;
        check("h12_hh", hh(), 12);
        check("h12_pm", int'(pm_out), 1);
        pulse_set(1);
        check("h13_hh_12h", hh(), 1);
        check("h13_pm_12h", int'(pm_out), 1);
        fmt_12h = 1'b0;
        #1;
        check("h13_hh_24h", hh(), 13);
        check("h13_pm_24h", int'(pm_out), 0);
        pulse_set(11);
        fmt_12h = 1'b1;
        #1;
        check("h0_hh_12h", hh(), 12);
        check("h0_pm_12h", int'(pm_out), 0);
        fmt_12h = 1'b0;
        $display("12h display section done");

        // Midnight wrap
        do_reset();
        goto_time(23, 59);
        step(227);
        check("wrap_pre_hhmm", hh() * 100 + mm(), 2359);
        check("wrap_pre_sec", int'(seconds_out), 58);
        step(8);
        check("wrap_digits", {28'd0, tens_hours_out, units_hours_out[1:0]} == 0 ? hh() * 100 + mm() : hh() * 100 + mm(), 0);
        check("wrap_digit_th", int'(tens_hours_out), 0);
        check("wrap_digit_uh", int'(units_hours_out), 0);
        check("wrap_digit_tm", int'(tens_minutes_out), 0);
        check("wrap_digit_um", int'(units_minutes_out), 0);
        check("wrap_sec", int'(seconds_out), 0);
        $display("wrap section done");

        // Dual alarm at 06:30, lowest index reported, ring length
        do_reset();
        prog_alarms_0630();
        check("prog_en", int'(alarm_en_out), 3);
        check("prog_state", int'(state_out), 0);
        goto_time(6, 29);
        step(234);
        check("alA_pre_sec", int'(seconds_out), 59);
        check("alA_pre_hhmm", hh() * 100 + mm(), 629);
        check("alA_pre_sound", int'(alarm_sound), 0);
        step();
        check("alA_sound", int'(alarm_sound), 1);
        check("alA_idx", int'(alarm_idx_out), 0);
        check("alA_hhmmss", hh() * 10000 + mm() * 100 + int'(seconds_out), 63000);
        ring_len = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (alarm_sound) ring_len++;
        end
        check("alA_ring_len", ring_len, 12);
        check("alA_ring_off", int'(alarm_sound), 0);
        $display("dual alarm ring length %0d", ring_len);

        // Acknowledge during ring
        goto_time(0, 59);
        step(235);
        check("alB_sound", int'(alarm_sound), 1);
        step(2);
        check("alB_pre_ack", int'(alarm_sound), 1);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        check("alB_ack_off", int'(alarm_sound), 0);
        step();
        check("alB_stays_off", int'(alarm_sound), 0);
        $display("ack section done");

        // Move alarm1 to 06:31, then acknowledge in the trigger cycle
        pulse_mode(6);
        check("alC_edit_state", int'(state_out), 4);
        check("alC_edit_idx", int'(alarm_idx_out), 1);
        pulse_set(1);
        check("alC_edit_mm", mm(), 31);
        pulse_mode(2);
        check("alC_back_state", int'(state_out), 0);
        goto_time(0, 0);
        step(234);
        check("alC_pre_hhmmss", hh() * 10000 + mm() * 100 + int'(seconds_out), 63059);
        check("alC_pre_sound", int'(alarm_sound), 0);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        check("alC_trig_wins", int'(alarm_sound), 1);
        check("alC_idx", int'(alarm_idx_out), 1);

        // Asynchronous reset while ringing
        #2;
        rst = 1'b0;
        #1;
        check("rst_ring_sound", int'(alarm_sound), 0);
        check("rst_ring_en", int'(alarm_en_out), 0);
        check("rst_ring_sec", int'(seconds_out), 0);
        check("rst_ring_hhmm", hh() * 100 + mm(), 0);
        step();
        rst = 1'b1;
        step(2);
        check("rst_ring_after", int'(alarm_sound), 0);
        $display("mid-ring reset section done");

        // Stopwatch wrap at 59:59 and clear against a coincident tick
        do_reset();
        pulse_mode(7);
        check("sw_state", int'(state_out), 5);
        pulse_set(1);
        waited = 0;
        while (!(stopwatch_min_out == 6'd59 && stopwatch_sec_out == 6'd59) && waited < 15000) begin
            step();
            waited++;
        end
        check("sw_reach_5959", waited < 15000 ? 1 : 0, 1);
        step(3);
        check("sw_hold_5959", int'(stopwatch_min_out) * 60 + int'(stopwatch_sec_out), 3599);
        step();
        check("sw_wrap", int'(stopwatch_min_out) * 60 + int'(stopwatch_sec_out), 0);
        waited = 0;
        while (stopwatch_sec_out != 6'd5 && waited < 40) begin
            step();
            waited++;
        end
        check("sw_reach_5", int'(stopwatch_sec_out), 5);
        step(3);
        sw_clr = 1'b1;
        step();
        sw_clr = 1'b0;
        check("sw_clr_wins", int'(stopwatch_min_out) * 60 + int'(stopwatch_sec_out), 0);
        step(4);
        check("sw_still_runs", int'(stopwatch_sec_out), 1);
        $display("stopwatch section done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
